// File: rtl/sync_initiator.sv
// Sweep initiator: issues count requests (first, first+1, ...) one at a time to a
// valid/ready responder and accumulates the responses, aborting on a response timeout.
module sync_initiator #(
  parameter int N       = 16,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         start,
  input  logic [N-1:0] first,
  input  logic [N-1:0] count,
  output logic         req_valid,
  input  logic         req_ready,
  output logic [N-1:0] req_data,
  input  logic         resp_valid,
  output logic         resp_ready,
  input  logic [N-1:0] resp_data,
  output logic         busy,
  output logic         done,
  output logic         timeout,
  output logic [N-1:0] last_result,
  output logic [N-1:0] sum,
  output logic [N-1:0] resp_count
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [N-1:0]  ONE        = N'(1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  op;
  logic [N-1:0]  remaining;
  logic [TW-1:0] timer;

  function automatic logic [N-1:0] wrap_add(input logic [N-1:0] a, input logic [N-1:0] b);
    return a + b;
  endfunction

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // A response in the final WAIT cycle takes priority over the timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = (count != '0) ? S_SEND : S_DONE;
      S_SEND: if (req_ready) state_nxt = S_WAIT;
      S_WAIT: begin
        if (resp_valid)               state_nxt = (remaining == ONE) ? S_DONE : S_SEND;
        else if (timer == TIMER_LAST) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_SEND: begin
        req_valid = 1'b1;
        busy      = 1'b1;
      end
      S_WAIT: begin
        resp_ready = 1'b1;
        busy       = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign req_data = op;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      op          <= '0;
      remaining   <= '0;
      timer       <= '0;
      timeout     <= 1'b0;
      last_result <= '0;
      sum         <= '0;
      resp_count  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sum        <= '0;
            resp_count <= '0;
            timeout    <= 1'b0;
            if (count != '0) begin
              op          <= first;
              remaining   <= count;
              last_result <= '0;
            end
          end
        end
        S_SEND: if (req_ready) timer <= '0;
        S_WAIT: begin
          if (resp_valid) begin
            last_result <= resp_data;
            sum         <= wrap_add(sum, resp_data);
            resp_count  <= wrap_add(resp_count, ONE);
            op          <= wrap_add(op, ONE);
            remaining   <= remaining - ONE;
          end else if (timer == TIMER_LAST) begin
            timeout <= 1'b1;
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_initiator.sv
// Bench for sync_initiator: a factorial responder with programmable ready-hold and
// response delays, and a sweep-level reference model computed from the request list.
module tb_sync_initiator;
  localparam int N   = 16;
  localparam int TMO = 8;

  logic         clk;
  logic         nrst;
  logic         start;
  logic [N-1:0] first;
  logic [N-1:0] count;
  logic         req_valid;
  logic         req_ready;
  logic [N-1:0] req_data;
  logic         resp_valid;
  logic         resp_ready;
  logic [N-1:0] resp_data;
  logic         busy;
  logic         done;
  logic         timeout;
  logic [N-1:0] last_result;
  logic [N-1:0] sum;
  logic [N-1:0] resp_count;

  sync_initiator #(.N(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .nrst(nrst), .start(start), .first(first), .count(count),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .busy(busy), .done(done), .timeout(timeout), .last_result(last_result),
    .sum(sum), .resp_count(resp_count)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Responder configuration: delays[i] < 0 means request i never gets a response.
  int           hold_cycles;
  int           delays[16];
  int           req_idx;
  int           last_xfer_cyc;
  logic [N-1:0] got_reqs[$];
  logic [N-1:0] exp_last;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] fact(input logic [N-1:0] n);
    logic [N-1:0] r;
    r = 1;
    for (int i = 2; i <= int'(n); i++) r = r * N'(i);
    return r;
  endfunction

  initial begin : responder
    logic         holding;
    logic         pend;
    int           hold_cnt;
    int           dly;
    logic [N-1:0] hold_data;
    logic [N-1:0] pend_data;
    req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;
    holding = 1'b0; pend = 1'b0; hold_cnt = 0; dly = 0; hold_data = '0; pend_data = '0;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        req_ready = 1'b0; resp_valid = 1'b0; holding = 1'b0; pend = 1'b0;
      end else begin
        if (resp_valid) begin
          resp_valid = 1'b0;
          pend = 1'b0;
        end else if (req_ready) begin
          req_ready = 1'b0;
          pend = 1'b1;
          pend_data = fact(hold_data);
          dly = (req_idx < 16) ? delays[req_idx] : 0;
          req_idx++;
        end
        if (pend && !resp_valid && dly >= 0) begin
          if (dly == 0) begin
            resp_valid = 1'b1;
            resp_data = pend_data;
          end else dly--;
        end
        if (pend && dly < 0 && done) pend = 1'b0;
        if (holding) begin
          check("req_valid_held", req_valid, 1);
          check("req_data_held", req_data, hold_data);
        end else if (!pend && !req_ready && req_valid) begin
          holding = 1'b1;
          hold_data = req_data;
          hold_cnt = 0;
        end
        if (holding) begin
          if (hold_cnt >= hold_cycles) begin
            req_ready = 1'b1;
            holding = 1'b0;
            got_reqs.push_back(hold_data);
            last_xfer_cyc = cyc + 1;
          end else hold_cnt++;
        end
      end
    end
  end

  task automatic run_sweep(input string name, input logic [N-1:0] f, input logic [N-1:0] c,
                           input bit poke_start);
    logic [N-1:0] exp_reqs[$];
    logic [N-1:0] exp_sum, exp_cnt, r;
    logic         exp_to;
    int           dones, done_cyc;
    bit           saw_busy, saw_req;
    exp_sum = '0; exp_cnt = '0; exp_to = 1'b0;
    if (c != '0) exp_last = '0;
    for (int i = 0; i < int'(c); i++) begin
      exp_reqs.push_back(f + N'(i));
      if (delays[i] < 0 || delays[i] >= TMO) begin
        exp_to = 1'b1;
        break;
      end
      r = fact(f + N'(i));
      exp_sum = exp_sum + r;
      exp_cnt = exp_cnt + 1'b1;
      exp_last = r;
    end

    got_reqs.delete();
    req_idx = 0;
    @(negedge clk);
    first = f; count = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0; done_cyc = -1; saw_busy = 0; saw_req = 0;
    for (int k = 0; k < 400 && dones == 0; k++) begin
      start = 1'b0;
      if (busy) saw_busy = 1;
      if (req_valid) saw_req = 1;
      if (done) begin
        dones++;
        done_cyc = cyc;
      end else if (poke_start && busy) begin
        start = 1'($urandom_range(1, 0));
        first = N'($urandom);
        count = N'($urandom);
      end
      if (dones == 0) @(negedge clk);
    end
    start = 1'b0;
    check({name, "_done_seen"}, dones, 1);
    repeat (5) begin
      @(negedge clk);
      if (done) dones++;
      if (busy) saw_busy = 1;
      if (req_valid) saw_req = 1;
    end
    check({name, "_done_pulses"}, dones, 1);
    check({name, "_req_seen"}, saw_req, c != '0);
    check({name, "_busy_seen"}, saw_busy, c != '0);
    if (exp_to) check({name, "_timeout_latency"}, done_cyc - last_xfer_cyc, TMO);
    check({name, "_timeout"}, timeout, exp_to);
    check({name, "_sum"}, sum, exp_sum);
    check({name, "_resp_count"}, resp_count, exp_cnt);
    if (c != '0) check({name, "_last_result"}, last_result, exp_last);
    check({name, "_num_reqs"}, got_reqs.size(), exp_reqs.size());
    for (int i = 0; i < exp_reqs.size() && i < got_reqs.size(); i++)
      check({name, "_req_data"}, got_reqs[i], exp_reqs[i]);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_req_valid"}, req_valid, 0);
    check({name, "_resp_ready"}, resp_ready, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_timeout"}, timeout, 0);
    check({name, "_last_result"}, last_result, 0);
    check({name, "_sum"}, sum, 0);
    check({name, "_resp_count"}, resp_count, 0);
    check({name, "_req_data"}, req_data, 0);
  endtask

  initial begin
    int  c;
    bit  reached;
    nrst = 1'b1; start = 1'b0; first = '0; count = '0;
    hold_cycles = 0; req_idx = 0; last_xfer_cyc = 0; exp_last = '0;
    foreach (delays[i]) delays[i] = 0;
    #1 nrst = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk);
    nrst = 1'b1;

    run_sweep("fact8", 16'd8, 16'd1, 0);

    foreach (delays[i]) delays[i] = $urandom_range(3, 0);
    run_sweep("fact1to5", 16'd1, 16'd5, 0);

    foreach (delays[i]) delays[i] = 0;
    hold_cycles = 3;
    run_sweep("hold3", 16'd8, 16'd1, 0);
    hold_cycles = 0;

    delays[0] = -1;
    run_sweep("no_resp", 16'd4, 16'd1, 0);

    foreach (delays[i]) delays[i] = TMO - 1;
    run_sweep("last_cycle_resp", 16'd2, 16'd3, 0);

    foreach (delays[i]) delays[i] = 1;
    delays[1] = TMO;
    run_sweep("late_resp", 16'd6, 16'd4, 0);

    foreach (delays[i]) delays[i] = 0;
    run_sweep("count0", 16'd7, 16'd0, 0);
    run_sweep("start_in_busy", 16'd3, 16'd4, 1);

    for (int t = 0; t < 8; t++) begin
      c = $urandom_range(6, 1);
      foreach (delays[i]) delays[i] = $urandom_range(TMO - 1, 0);
      if ($urandom_range(3, 0) == 0) delays[$urandom_range(c - 1, 0)] = ($urandom_range(1, 0) == 1) ? TMO : -1;
      hold_cycles = $urandom_range(2, 0);
      run_sweep("random", N'($urandom_range(12, 0)), N'(c), 1'($urandom_range(1, 0)));
    end
    hold_cycles = 0;

    foreach (delays[i]) delays[i] = 3;
    got_reqs.delete();
    req_idx = 0;
    @(negedge clk);
    first = 16'd1; count = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reached = 0;
    for (int k = 0; k < 200 && !reached; k++) begin
      if (resp_ready && resp_count == 16'd2) reached = 1;
      else @(negedge clk);
    end
    check("mid_sweep_wait_reached", reached, 1);
    #2 nrst = 1'b0;
    #1 check_all_zero("async_reset");
    repeat (3) begin
      @(negedge clk);
      check("reset_hold_done", done, 0);
    end
    nrst = 1'b1;
    exp_last = '0;
    foreach (delays[i]) delays[i] = 2;
    run_sweep("after_reset", 16'd3, 16'd1, 0);
    check("after_reset_fact3", last_result, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sync_initiator.md
SYNC_INITIATOR -- requirements
Module: sync_initiator

Interface
REQ-001 SHALL have parameter N, default 16, meaning operand/result width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning max WAIT cycles without a response before abort.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  begin a sweep when sampled high in IDLE.
REQ-006 SHALL have port first  input  N  first operand of the sweep.
REQ-007 SHALL have port count  input  N  number of requests in the sweep.
REQ-008 SHALL have port req_valid  output  1  request offered to responder (drives its in_valid).
REQ-009 SHALL have port req_ready  input  1  responder accepts request (from its in_ready).
REQ-010 SHALL have port req_data  output  N  request operand (drives its in0).
REQ-011 SHALL have port resp_valid  input  1  response present (from its out_valid).
REQ-012 SHALL have port resp_ready  output  1  initiator accepts response (drives its out_ready).
REQ-013 SHALL have port resp_data  input  N  response value (from its out0).
REQ-014 SHALL have port busy  output  1  high in SEND or WAIT.
REQ-015 SHALL have port done  output  1  one-cycle pulse at sweep end.
REQ-016 SHALL have port timeout  output  1  sticky abort flag, cleared by next accepted start.
REQ-017 SHALL have port last_result  output  N  most recent accepted resp_data.
REQ-018 SHALL have port sum  output  N  modulo-2^N sum of accepted responses in the sweep.
REQ-019 SHALL have port resp_count  output  N  number of responses accepted in the sweep.

Function
REQ-020 SHALL implement states IDLE, SEND, WAIT, DONE; outputs req_valid, resp_ready, busy, done decoded from state only (Moore).
REQ-021 SHALL, in IDLE with start=1 and count!=0, latch op=first, remaining=count, clear sum, resp_count, timeout, last_result, and enter SEND next cycle.
REQ-022 SHALL, in IDLE with start=1 and count=0, clear timeout/sum/resp_count and enter DONE without asserting req_valid.
REQ-023 SHALL, in SEND, drive req_valid=1 and req_data=op, holding both stable until req_valid&&req_ready, then enter WAIT with timer=0.
REQ-024 SHALL, in WAIT, drive resp_ready=1; on resp_valid capture last_result=resp_data, sum+=resp_data (wrap), resp_count+=1, op+=1 (wrap), remaining-=1.
REQ-025 SHALL, after the response accepted with remaining=1, enter DONE; otherwise return to SEND (one outstanding request max; one idle cycle between responses and next request is permitted).
REQ-026 SHALL, in WAIT without resp_valid, increment timer; when timer reaches TIMEOUT, set timeout=1 and enter DONE without altering result registers.
REQ-027 SHALL hold resp_ready=0 outside WAIT; resp_valid outside WAIT is ignored.
REQ-028 SHALL hold req_valid=0 outside SEND; req_ready outside SEND is ignored.
REQ-029 SHALL, in DONE, assert done=1 for exactly one cycle, busy=0, then enter IDLE; start sampled in DONE, SEND or WAIT is ignored.
REQ-030 SHALL hold last_result, sum, resp_count, timeout stable in IDLE until the next accepted start.
REQ-031 SHALL treat a response arriving in the same cycle timer reaches TIMEOUT as accepted (response wins, no timeout).

Reset
REQ-032 SHALL, on nrst=0, immediately enter IDLE and force req_valid=0, resp_ready=0, busy=0, done=0, timeout=0, last_result=0, sum=0, resp_count=0, op=0, remaining=0, timer=0.
REQ-033 SHALL, on reset asserted mid-sweep, abandon the sweep without emitting done; first start after release begins a fresh sweep.

Verification
REQ-034 SHALL verify: factorial responder, first=8, count=1, start pulse -> one request req_data=8, last_result=40320, sum=40320, resp_count=1, done pulse, timeout=0.
REQ-035 SHALL verify: factorial responder, first=1, count=5 -> requests 1..5 in order, last_result=120, sum=153, resp_count=5, single done pulse.
REQ-036 SHALL verify: req_ready held low 3 cycles in SEND -> req_valid=1 and req_data unchanged all 3 cycles, transfer on 4th, results as REQ-034.
REQ-037 SHALL verify: TIMEOUT=8, responder never asserts resp_valid -> done 8 WAIT cycles after request transfer, timeout=1, resp_count=0, sum=0.
REQ-038 SHALL verify: count=0 start -> done pulse without any req_valid, busy never high; start during busy ignored (count unaffected).
REQ-039 SHALL verify: nrst low during WAIT of a count=5 sweep -> all outputs 0 immediately, no done; next start first=3, count=1 -> last_result=6.
